// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Opcode encodings and flag-vector bit positions shared by the
//             pipelined ALU and its combinational core.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   // Opcode encodings; 3 bits, every code is a legal operation
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_ADC = 3'b111;

   // Bit positions inside the 4-bit registered flag vector
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_if
//  Purpose  : Operand-side and result-side valid/ready bundle of alu_pipe.
//             master = issue/writeback side, slave = the ALU pipeline.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             zero_flag;
   logic             neg_flag;
   logic             ovf_flag;

   modport master (
      output in_valid, A, B, op, out_ready,
      input  in_ready, out_valid, result, carry_out, zero_flag, neg_flag, ovf_flag
   );

   modport slave (
      input  in_valid, A, B, op, out_ready,
      output in_ready, out_valid, result, carry_out, zero_flag, neg_flag, ovf_flag
   );
endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Purely combinational ALU datapath: (a, b, op, cin) -> result,
//             carry/borrow and signed overflow. Z/N are derived by the caller.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             v
);
   localparam int c_MSB = WIDTH - 1;

   logic [SHAMT_W-1:0] w_amt;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_adc;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH:0]     w_shl;
   logic [WIDTH:0]     w_shr;

   assign w_amt  = b[SHAMT_W-1:0];
   // All arithmetic done at WIDTH+1 so the top bit is the carry/borrow
   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_adc  = w_sum + {{WIDTH{1'b0}}, cin};
   assign w_diff = {1'b0, a} - {1'b0, b};
   // Extra guard bit catches the last bit shifted out; it is 0 when amt==0
   assign w_shl  = {1'b0, a} << w_amt;
   assign w_shr  = {a, 1'b0} >> w_amt;

   // Opcode decode: select result and flags, logic ops leave C and V clear
   always_comb begin
      result = '0;
      c      = 1'b0;
      v      = 1'b0;
      case (op)
         OP_ADD: begin
            result = w_sum[c_MSB:0];
            c      = w_sum[WIDTH];
            v      = (a[c_MSB] == b[c_MSB]) && (w_sum[c_MSB] != a[c_MSB]);
         end
         OP_SUB: begin
            result = w_diff[c_MSB:0];
            c      = w_diff[WIDTH];
            v      = (a[c_MSB] != b[c_MSB]) && (w_diff[c_MSB] != a[c_MSB]);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_SHL: begin
            result = w_shl[c_MSB:0];
            c      = w_shl[WIDTH];
         end
         OP_SHR: begin
            result = w_shr[WIDTH:1];
            c      = w_shr[0];
         end
         OP_ADC: begin
            result = w_adc[c_MSB:0];
            c      = w_adc[WIDTH];
            v      = (a[c_MSB] == b[c_MSB]) && (w_adc[c_MSB] != a[c_MSB]);
         end
         default: ;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Two-stage valid/ready ALU pipeline. S1 registers operands, S2
//             computes and registers result + C/Z/N/V. carry_reg feeds ADC.
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_pipe_if.slave bus
);
   localparam logic [3:0] c_FLAGS_RST = 4'(1) << FLAG_Z;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [2:0]       r_s1_op;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic             r_carry;

   logic [WIDTH-1:0] w_core_result;
   logic             w_core_c;
   logic             w_core_v;
   logic [3:0]       w_flags;
   logic             w_s2_load;
   logic             w_in_ready;
   logic             w_s1_load;

   // S2 may load when it is empty or its current result is leaving this cycle
   assign w_s2_load  = r_s1_valid && (!r_out_valid || bus.out_ready);
   assign w_in_ready = !r_s1_valid || w_s2_load;
   assign w_s1_load  = bus.in_valid && w_in_ready;

   alu_core #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_core (
      .a      (r_s1_a),
      .b      (r_s1_b),
      .op     (r_s1_op),
      .cin    (r_carry),
      .result (w_core_result),
      .c      (w_core_c),
      .v      (w_core_v)
   );

   // Assemble the flag vector for the result about to enter S2
   always_comb begin
      w_flags         = '0;
      w_flags[FLAG_C] = w_core_c;
      w_flags[FLAG_Z] = (w_core_result == '0);
      w_flags[FLAG_N] = w_core_result[WIDTH-1];
      w_flags[FLAG_V] = w_core_v;
   end

   // S1 operand register: fill on accept, empty when its beat moves to S2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= OP_ADD;
      end else if (w_s1_load) begin
         r_s1_valid <= 1'b1;
         r_s1_a     <= bus.A;
         r_s1_b     <= bus.B;
         r_s1_op    <= bus.op;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   // S2 output register and carry_reg; fields only change on a load, so a stalled result holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= c_FLAGS_RST;
         r_carry     <= 1'b0;
      end else if (w_s2_load) begin
         r_out_valid <= 1'b1;
         r_result    <= w_core_result;
         r_flags     <= w_flags;
         r_carry     <= w_core_c;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.carry_out = r_flags[FLAG_C];
   assign bus.zero_flag = r_flags[FLAG_Z];
   assign bus.neg_flag  = r_flags[FLAG_N];
   assign bus.ovf_flag  = r_flags[FLAG_V];
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Self-checking bench for alu_pipe (WIDTH=8): directed corner
//             cases plus randomized traffic against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(W)) bus ();

   alu_pipe #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [11:0] exp;
      int          acc_cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [11:0] got_q[$];
   int          n_checks = 0;
   int          n_fails  = 0;
   int          cyc      = 0;
   int          m_carry  = 0;
   int          n_acc    = 0;
   bit          lat_mode = 1'b0;
   bit          prev_stall = 1'b0;
   logic [11:0] prev_pk;
   logic        s_in_ready;
   int          t5_op[8];
   int          t5_a[8];
   int          t5_b[8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // {result, C, Z, N, V}
   function automatic logic [11:0] pk(input int r, input int c, input int z, input int n, input int v);
      return {r[7:0], c[0], z[0], n[0], v[0]};
   endfunction

   function automatic int sgn(input int x);
      return (x > 127) ? x - 256 : x;
   endfunction

   // Reference ALU in plain integer arithmetic
   function automatic logic [11:0] ref_alu(input int op, input int a, input int b, input int cin);
      int r, c, v, amt, s;
      c   = 0;
      v   = 0;
      amt = b % 8;
      case (op)
         0: begin r = a + b; c = r / 256; s = sgn(a) + sgn(b); v = (s > 127 || s < -128); end
         1: begin r = a - b; c = (a < b); s = sgn(a) - sgn(b); v = (s > 127 || s < -128); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin r = a << amt; c = (amt == 0) ? 0 : (a >> (8 - amt)) & 1; end
         6: begin r = a >> amt; c = (amt == 0) ? 0 : (a >> (amt - 1)) & 1; end
         default: begin r = a + b + cin; c = r / 256; s = sgn(a) + sgn(b) + cin; v = (s > 127 || s < -128); end
      endcase
      r = r & 255;
      return pk(r, c, (r == 0), (r >> 7) & 1, v);
   endfunction

   function automatic logic [11:0] cur_pk();
      return {bus.result, bus.carry_out, bus.zero_flag, bus.neg_flag, bus.ovf_flag};
   endfunction

   // One clock cycle: drive at negedge, sample 1ns later, score, advance to next negedge
   task automatic step(input bit iv, input int op, input int a, input int b, input bit ordy);
      logic [11:0] cur;
      exp_t        e;
      bus.in_valid  = iv;
      bus.op        = op[2:0];
      bus.A         = a[7:0];
      bus.B         = b[7:0];
      bus.out_ready = ordy;
      #1;
      cur        = cur_pk();
      s_in_ready = bus.in_ready;
      if (prev_stall)
         check("hold_stable", {19'd0, bus.out_valid, cur}, {19'd0, 1'b1, prev_pk});
      if (bus.out_valid && ordy) begin
         check("out_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result_flags", {20'd0, cur}, {20'd0, e.exp});
            if (lat_mode)
               check("latency", cyc - e.acc_cyc, 2);
            got_q.push_back(cur);
         end
      end
      prev_stall = bus.out_valid && !ordy;
      prev_pk    = cur;
      if (iv && bus.in_ready) begin
         e.exp     = ref_alu(op, a, b, m_carry);
         m_carry   = int'(e.exp[3]);
         e.acc_cyc = cyc;
         exp_q.push_back(e);
         n_acc++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() > 0; i++)
         step(1'b0, 0, 0, 0, 1'b1);
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = 3'd0;
      bus.A         = '0;
      bus.B         = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_outputs", {20'd0, cur_pk()}, {20'd0, pk(0, 0, 1, 0, 0)});
      check("rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed corner cases, no backpressure, latency checked
      lat_mode = 1'b1;
      got_q.delete();
      step(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b1);
      drain();
      check("t1_add_wrap", {20'd0, got_q[0]}, {20'd0, pk(8'h00, 1, 1, 0, 0)});

      got_q.delete();
      step(1'b1, OP_SUB, 8'h80, 8'h01, 1'b1);
      step(1'b1, OP_SUB, 8'h01, 8'h02, 1'b1);
      drain();
      check("t2_sub_ovf", {20'd0, got_q[0]}, {20'd0, pk(8'h7F, 0, 0, 0, 1)});
      check("t2_sub_borrow", {20'd0, got_q[1]}, {20'd0, pk(8'hFF, 1, 0, 1, 0)});

      got_q.delete();
      step(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b1);
      step(1'b1, OP_ADC, 8'h00, 8'h00, 1'b1);
      drain();
      check("t3_adc_chain", {20'd0, got_q[1]}, {20'd0, pk(8'h01, 0, 0, 0, 0)});

      got_q.delete();
      step(1'b1, OP_SHL, 8'h81, 8'h01, 1'b1);
      step(1'b1, OP_SHR, 8'h81, 8'h01, 1'b1);
      step(1'b1, OP_SHL, 8'h81, 8'h00, 1'b1);
      step(1'b1, OP_SHR, 8'h81, 8'h00, 1'b1);
      drain();
      check("t4_shl1", {20'd0, got_q[0]}, {20'd0, pk(8'h02, 1, 0, 0, 0)});
      check("t4_shr1", {20'd0, got_q[1]}, {20'd0, pk(8'h40, 1, 0, 0, 0)});
      check("t4_shl0", {20'd0, got_q[2]}, {20'd0, pk(8'h81, 0, 0, 1, 0)});
      check("t4_shr0", {20'd0, got_q[3]}, {20'd0, pk(8'h81, 0, 0, 1, 0)});
      lat_mode = 1'b0;

      // Stream of 8 ops with 3 cycles of downstream stall at the start
      for (int i = 0; i < 8; i++) begin
         t5_op[i] = $urandom_range(0, 7);
         t5_a[i]  = $urandom_range(0, 255);
         t5_b[i]  = $urandom_range(0, 255);
      end
      got_q.delete();
      n_acc = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, t5_op[n_acc], t5_a[n_acc], t5_b[n_acc], 1'b0);
         if (i == 2)
            check("t5_in_ready_low", s_in_ready, 0);
      end
      check("t5_accepted_2", n_acc, 2);
      for (int i = 0; i < 40 && n_acc < 8; i++)
         step(1'b1, t5_op[n_acc], t5_a[n_acc], t5_b[n_acc], 1'b1);
      drain();
      check("t5_retired_8", got_q.size(), 8);

      // Reset while a result is stalled on the output
      step(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b0);
      step(1'b0, 0, 0, 0, 1'b0);
      bus.out_ready = 1'b0;
      #1;
      check("t6_pre_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", bus.out_valid, 0);
      check("t6_rst_outputs", {20'd0, cur_pk()}, {20'd0, pk(0, 0, 1, 0, 0)});
      check("t6_rst_in_ready", bus.in_ready, 1);
      exp_q.delete();
      m_carry    = 0;
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      got_q.delete();
      step(1'b1, OP_ADC, 8'h00, 8'h00, 1'b1);
      drain();
      check("t6_adc_after_rst", {20'd0, got_q[0]}, {20'd0, pk(8'h00, 0, 1, 0, 0)});

      // Randomized traffic with random backpressure
      for (int i = 0; i < 3000; i++) begin
         int a, b, sel;
         sel = $urandom_range(0, 3);
         a   = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h80 : $urandom_range(0, 255);
         b   = ($urandom_range(0, 3) == 0) ? 8'h7F : $urandom_range(0, 255);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7), a, b, $urandom_range(0, 9) < 7);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule
`default_nettype wire
